ps2_scan_sequencer: RTL
=======================

// Module: ps2_scan_sequencer
// PURPOSE
//  Sequences the raw byte stream from the PS/2 receiver (scan_code/scan_ready) into complete key events.
//  Decodes Set-2 prefixes (E0 extended, F0 break, E1 pause) and filters keyboard control bytes.
//  Buffers events in a FIFO with a valid/ready output handshake.
//  Sits between the PS/2 receiver and the keymap/application logic.
// PARAMETERS
//  DEPTH        8       event FIFO depth in entries; power of 2, >=2
//  TIMEOUT_CYC  100000  max clk cycles allowed between bytes of one multi-byte sequence
// PORTS
//  clk         in   1   system clock; all logic on posedge
//  reset_n     in   1   reset; one clock; reset is synchronous and active-low
//  scan_code   in   8   byte from PS/2 receiver; valid only when scan_ready=1
//  scan_ready  in   1   1-cycle strobe: scan_code holds a new byte
//  evt_valid   out  1   FIFO head holds an event
//  evt_ready   in   1   consumer accepts head event
//  evt_code    out  8   head event key code (final byte of sequence)
//  evt_ext     out  1   head event had E0 prefix (or is pause)
//  evt_break   out  1   head event is a release (F0 seen)
//  fifo_count  out  $clog2(DEPTH)+1  number of stored events
//  overflow    out  1   sticky: event dropped because FIFO full
//  frame_err   out  1   sticky: protocol error or inter-byte timeout
//  clr_status  in   1   clears overflow and frame_err
//  seq_state   out  3   current FSM state (debug)
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): FSM->IDLE, FIFO emptied, timeout counter=0; all outputs 0.
//  Reset mid-sequence discards the partial sequence and all stored events.
//  FSM encoding: IDLE=0, EXT=1, BRK=2, EXT_BRK=3, PAUSE=4. Bytes are processed only on edges with scan_ready=1.
//  Any state, byte 00 or FF (keyboard overrun) -> frame_err=1, ->IDLE, no event.
//  IDLE: E0->EXT; F0->BRK; E1->PAUSE (pcnt=0).
//   IDLE: FA/AA/EE/FE/FC/FD are ignored and the FSM stays IDLE.
//   IDLE: any other byte b -> push {b,ext=0,brk=0}.
//  EXT: F0->EXT_BRK; E0/E1 -> frame_err, ->IDLE; other b -> push {b,1,0}, ->IDLE.
//  BRK: E0/E1/F0 -> frame_err, ->IDLE; other b -> push {b,0,1}, ->IDLE.
//  EXT_BRK: E0/E1/F0 -> frame_err, ->IDLE; other b -> push {b,1,1}, ->IDLE.
//  PAUSE: bytes are not validated (00/FF rule still applies); pcnt increments per byte.
//   PAUSE: on the 7th byte after E1 -> push {E1,1,0}, ->IDLE.
//  Timeout: the counter clears on every scan_ready and is held at 0 in IDLE.
//   When state!=IDLE and count reaches TIMEOUT_CYC-1 with no byte -> ->IDLE, frame_err=1, partial sequence dropped.
//   A byte arriving on the timeout edge wins: it is processed normally and no error is raised.
//  Latency: push on the scan_ready edge; evt_valid/evt_* reflect the event on the next cycle (1 clk).
//  FIFO is first-word-fall-through: evt_* = head entry; evt_valid = (fifo_count!=0).
//   Pop occurs when evt_valid&&evt_ready at posedge.
//   evt_* are don't-care when evt_valid=0 but must not be X after reset.
//  Full: a push with no pop -> event dropped, overflow=1, contents unchanged.
//   Push+pop on the same edge while full -> both succeed and count is unchanged.
//  Empty: evt_ready is ignored and the count never underflows. Pointers wrap modulo DEPTH.
//  Sticky flags: set has priority over clr_status on the same edge.
// TESTING
//  1. 1C (A make) -> exactly one event {1C,0,0}; evt_valid 1 clk after strobe; fifo_count=1; pop -> 0.
//  2. E0 F0 74 (right-arrow break) -> one event {74,1,1}; no events for the prefixes; seq_state 0->1->3->0.
//  3. E1 14 77 E1 F0 14 F0 77 -> exactly one event {E1,1,0} after the 8th byte; F0/E1 inside are not errors.
//  4. evt_ready=0, DEPTH+1 makes -> fifo_count=DEPTH, overflow=1, first DEPTH codes read back in order.
//     Full with simultaneous push+pop -> count unchanged, no overflow.
//  5. F0 then idle TIMEOUT_CYC clks -> frame_err=1, IDLE; then 1C -> make {1C,0,0}, not a break.
//     Assert clr_status -> flag clears.
//  6. Send E0, assert reset_n=0 one clk, then 74 -> event {74,0,0}; FIFO empty and flags 0 after reset.

Source files
------------

// File: rtl/ps2_scan_sequencer_if.sv
// rtl/ps2_scan_sequencer_if.sv - scan byte input and key event output handshake bundle
interface ps2_scan_sequencer_if;
  logic [7:0] scan_code;
  logic       scan_ready;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;

  modport slave (
    input  scan_code, scan_ready, evt_ready,
    output evt_valid, evt_code, evt_ext, evt_break
  );

  modport master (
    output scan_code, scan_ready, evt_ready,
    input  evt_valid, evt_code, evt_ext, evt_break
  );
endinterface

// File: rtl/ps2_scan_sequencer.sv
// rtl/ps2_scan_sequencer.sv - PS/2 Set-2 byte sequencer with prefix decode and FWFT event FIFO
module ps2_scan_sequencer #(
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  ps2_scan_sequencer_if.slave      bus,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     frame_err,
  input  logic                     clr_status,
  output logic [2:0]               seq_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXT     = 3'd1,
    S_BRK     = 3'd2,
    S_EXT_BRK = 3'd3,
    S_PAUSE   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      pcnt_q, pcnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            push;
  logic [9:0]      push_data;
  logic            err_set;

  logic [9:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            overflow_q, frame_err_q;
  logic            full, pop, push_ok, ovf_set;

  logic [7:0] b;
  assign b = bus.scan_code;

  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    push      = 1'b0;
    push_data = 10'd0;
    err_set   = 1'b0;
    if (bus.scan_ready || state_q == S_IDLE) tmo_d = '0;
    else                                     tmo_d = tmo_q + TW'(1);

    if (bus.scan_ready) begin
      if (b == 8'h00 || b == 8'hFF) begin
        err_set = 1'b1;
        state_d = S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (b == 8'hE0)      state_d = S_EXT;
            else if (b == 8'hF0) state_d = S_BRK;
            else if (b == 8'hE1) begin
              state_d = S_PAUSE;
              pcnt_d  = 3'd0;
            end else if (!(b == 8'hFA || b == 8'hAA || b == 8'hEE ||
                           b == 8'hFE || b == 8'hFC || b == 8'hFD)) begin
              push      = 1'b1;
              push_data = {b, 1'b0, 1'b0};
            end
          end
          S_EXT: begin
            if (b == 8'hF0) state_d = S_EXT_BRK;
            else if (b == 8'hE0 || b == 8'hE1) begin
              err_set = 1'b1;
              state_d = S_IDLE;
            end else begin
              push      = 1'b1;
              push_data = {b, 1'b1, 1'b0};
              state_d   = S_IDLE;
            end
          end
          S_BRK, S_EXT_BRK: begin
            state_d = S_IDLE;
            if (b == 8'hE0 || b == 8'hE1 || b == 8'hF0) begin
              err_set = 1'b1;
            end else begin
              push      = 1'b1;
              push_data = {b, (state_q == S_EXT_BRK), 1'b1};
            end
          end
          S_PAUSE: begin
            // The pause sequence is E1 plus seven opaque bytes, reported as one extended E1 event.
            if (pcnt_q == 3'd6) begin
              push      = 1'b1;
              push_data = {8'hE1, 1'b1, 1'b0};
              state_d   = S_IDLE;
            end else begin
              pcnt_d = pcnt_q + 3'd1;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end else if (state_q != S_IDLE && tmo_q == TMO_LAST) begin
      err_set = 1'b1;
      state_d = S_IDLE;
    end
  end

  assign full    = (count_q == CW'(DEPTH));
  assign pop     = (count_q != '0) && bus.evt_ready;
  assign push_ok = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      pcnt_q      <= 3'd0;
      tmo_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      tmo_q   <= tmo_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop);
      if (ovf_set)         overflow_q <= 1'b1;
      else if (clr_status) overflow_q <= 1'b0;
      if (err_set)         frame_err_q <= 1'b1;
      else if (clr_status) frame_err_q <= 1'b0;
    end
  end

  assign bus.evt_valid = (count_q != '0);
  assign bus.evt_code  = mem_q[rd_ptr_q][9:2];
  assign bus.evt_ext   = mem_q[rd_ptr_q][1];
  assign bus.evt_break = mem_q[rd_ptr_q][0];
  assign fifo_count    = count_q;
  assign overflow      = overflow_q;
  assign frame_err     = frame_err_q;
  assign seq_state     = state_q;
endmodule
